// File: rtl/spi_target_regfile_if.sv
// SPI pin bundle between an SPI master and the spi_target_regfile target.
// The master drives clock, data and select; the target drives MISO.
interface spi_target_regfile_if;
  logic sclk_i;
  logic mosi_i;
  logic cs_n_i;
  logic miso_o;

  modport master (output sclk_i, output mosi_i, output cs_n_i, input miso_o);
  modport slave  (input sclk_i, input mosi_i, input cs_n_i, output miso_o);
endinterface

// File: rtl/spi_target_regfile.sv
// Oversampled SPI target fronting a 128x8 register file, with a local read port.
// Optional macro SPI_TARGET_ERR_CNT_EN adds a saturating aborted-byte counter.
module spi_target_regfile #(
  parameter int         SYNC_STAGES  = 2,
  parameter int         IDLE_TIMEOUT = 64,
  parameter logic [7:0] RESET_VAL    = 8'h00
) (
  input  logic                 pclk_i,
  input  logic                 prst_n_i,
  spi_target_regfile_if.slave  spi,
  input  logic [6:0]           loc_addr_i,
  output logic [7:0]           loc_rdata_o,
  output logic                 wr_strobe_o,
  output logic [6:0]           wr_addr_o,
  output logic                 busy_o,
`ifdef SPI_TARGET_ERR_CNT_EN
  input  logic                 err_clr_i,
  output logic [7:0]           err_cnt_o,
`endif
  output logic [1:0]           state_dbg_o
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_WDATA, S_RDATA} state_t;

  localparam int TW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(IDLE_TIMEOUT - 1);

  logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, cs_sync_q;
  logic                   sclk_prev_q;
  logic                   sclk_s, mosi_s, cs_s, sclk_fall;

  state_t     state_q;
  logic [7:0] shift_q;
  logic [2:0] cnt_q;
  logic [TW-1:0] tmo_q;
  logic [6:0] addr_q;
  logic       miso_q;
  logic       wr_strobe_q;
  logic [6:0] wr_addr_q;
  logic [7:0] loc_rdata_q;
  logic [7:0] mem_q [128];

  logic [7:0] byte_c;
  logic       tmo_hit_c;

  always_ff @(posedge pclk_i or negedge prst_n_i) begin
    if (!prst_n_i) begin
      sclk_sync_q <= '1;
      mosi_sync_q <= '1;
      cs_sync_q   <= '1;
      sclk_prev_q <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi.sclk_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi.mosi_i};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi.cs_n_i};
      sclk_prev_q <= sclk_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_fall = sclk_prev_q & ~sclk_s;

  // Current partial byte with the incoming MOSI bit dropped into slot cnt_q.
  always_comb begin
    byte_c        = shift_q;
    byte_c[cnt_q] = mosi_s;
  end

  assign tmo_hit_c = (state_q != S_IDLE) && (cnt_q != 3'd0) && !sclk_fall &&
                     sclk_s && (tmo_q == TMO_LAST);

  always_ff @(posedge pclk_i or negedge prst_n_i) begin
    if (!prst_n_i) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      tmo_q       <= '0;
      addr_q      <= '0;
      miso_q      <= 1'b1;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      loc_rdata_q <= '0;
      for (int i = 0; i < 128; i++) mem_q[i] <= RESET_VAL;
    end else begin
      wr_strobe_q <= 1'b0;
      loc_rdata_q <= mem_q[loc_addr_i];
      if (cs_s) begin
        state_q <= S_IDLE;
        shift_q <= '0;
        cnt_q   <= '0;
        tmo_q   <= '0;
        miso_q  <= 1'b1;
      end else if (state_q == S_IDLE) begin
        miso_q  <= 1'b1;
        state_q <= S_ADDR;
        cnt_q   <= '0;
        tmo_q   <= '0;
      end else if (tmo_hit_c) begin
        state_q <= S_ADDR;
        shift_q <= '0;
        cnt_q   <= '0;
        tmo_q   <= '0;
        miso_q  <= 1'b1;
      end else if (sclk_fall) begin
        tmo_q <= '0;
        case (state_q)
          S_ADDR: begin
            if (cnt_q == 3'd7) begin
              addr_q <= byte_c[6:0];
              cnt_q  <= '0;
              if (byte_c[7]) begin
                state_q <= S_WDATA;
                shift_q <= '0;
              end else begin
                // Bit 0 must be on MISO before the first data-phase fall.
                state_q <= S_RDATA;
                shift_q <= mem_q[byte_c[6:0]];
                miso_q  <= mem_q[byte_c[6:0]][0];
              end
            end else begin
              shift_q <= byte_c;
              cnt_q   <= cnt_q + 3'd1;
            end
          end
          S_WDATA: begin
            if (cnt_q == 3'd7) begin
              mem_q[addr_q] <= byte_c;
              wr_strobe_q   <= 1'b1;
              wr_addr_q     <= addr_q;
              state_q       <= S_ADDR;
              shift_q       <= '0;
              cnt_q         <= '0;
            end else begin
              shift_q <= byte_c;
              cnt_q   <= cnt_q + 3'd1;
            end
          end
          S_RDATA: begin
            if (cnt_q == 3'd7) begin
              miso_q  <= 1'b1;
              state_q <= S_ADDR;
              shift_q <= '0;
              cnt_q   <= '0;
            end else begin
              miso_q <= shift_q[cnt_q + 3'd1];
              cnt_q  <= cnt_q + 3'd1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end else if (sclk_s && (cnt_q != 3'd0)) begin
        tmo_q <= tmo_q + 1'b1;
      end
    end
  end

`ifdef SPI_TARGET_ERR_CNT_EN
  logic [7:0] err_cnt_q;
  logic       abort_c;

  assign abort_c = (state_q != S_IDLE) && (cnt_q != 3'd0) && (cs_s || tmo_hit_c);

  always_ff @(posedge pclk_i or negedge prst_n_i) begin
    if (!prst_n_i) begin
      err_cnt_q <= '0;
    end else if (err_clr_i) begin
      err_cnt_q <= '0;
    end else if (abort_c && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_cnt_o = err_cnt_q;
`endif

  assign spi.miso_o  = miso_q;
  assign loc_rdata_o = loc_rdata_q;
  assign wr_strobe_o = wr_strobe_q;
  assign wr_addr_o   = wr_addr_q;
  assign busy_o      = (state_q != S_IDLE);
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_spi_target_regfile.sv
// Directed bench for spi_target_regfile: SPI master tasks, write/read scoreboards
// fed by the stimulus and drained by independent monitors.
module tb_spi_target_regfile;
  localparam int IDLE_TIMEOUT = 64;

  logic       pclk = 1'b0;
  logic       prst_n = 1'b0;
  logic [6:0] loc_addr;
  logic [7:0] loc_rdata;
  logic       wr_strobe;
  logic [6:0] wr_addr;
  logic       busy;
  logic [1:0] state_dbg;
`ifdef SPI_TARGET_ERR_CNT_EN
  logic       err_clr;
  logic [7:0] err_cnt;
`endif

  spi_target_regfile_if spi ();

  spi_target_regfile #(.SYNC_STAGES(2), .IDLE_TIMEOUT(IDLE_TIMEOUT), .RESET_VAL(8'h00)) dut (
    .pclk_i      (pclk),
    .prst_n_i    (prst_n),
    .spi         (spi),
    .loc_addr_i  (loc_addr),
    .loc_rdata_o (loc_rdata),
    .wr_strobe_o (wr_strobe),
    .wr_addr_o   (wr_addr),
    .busy_o      (busy),
`ifdef SPI_TARGET_ERR_CNT_EN
    .err_clr_i   (err_clr),
    .err_cnt_o   (err_cnt),
`endif
    .state_dbg_o (state_dbg)
  );

  // clock / reset
  always #5 pclk = ~pclk;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int errors = 0;
  int checks = 0;
  logic [6:0] exp_wr_q[$];
  logic [7:0] exp_rd_q[$];
  logic       rd_active = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // write-commit monitor
  always @(negedge pclk) begin
    if (prst_n && wr_strobe) begin
      if (exp_wr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got addr %0h expected no strobe", wr_addr);
      end else begin
        check("wr_addr", {25'b0, wr_addr}, {25'b0, exp_wr_q.pop_front()});
      end
    end
  end

  // read-data monitor: master samples MISO at each raw SCLK fall
  initial begin
    logic [7:0] bits;
    int nb;
    nb = 0;
    bits = '0;
    forever begin
      @(negedge spi.sclk_i);
      if (rd_active) begin
        bits[nb] = spi.miso_o;
        nb++;
        if (nb == 8) begin
          nb = 0;
          rd_active = 1'b0;
          if (exp_rd_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_read: got %0h expected nothing", bits);
          end else begin
            check("rd_data", {24'b0, bits}, {24'b0, exp_rd_q.pop_front()});
          end
          repeat (6) @(negedge pclk);
          check("miso_idle", {31'b0, spi.miso_o}, 32'd1);
        end
      end
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      spi.mosi_i = b[i];
      tick(4);
      spi.sclk_i = 1'b0;
      tick(4);
      spi.sclk_i = 1'b1;
    end
  endtask

  task automatic frame_start();
    spi.cs_n_i = 1'b0;
    tick(6);
  endtask

  task automatic frame_end();
    tick(6);
    spi.cs_n_i = 1'b1;
    spi.mosi_i = 1'b1;
    tick(8);
  endtask

  task automatic spi_write(input logic [6:0] a, input logic [7:0] d);
    exp_wr_q.push_back(a);
    send_bits({1'b1, a}, 8);
    tick(8);
    send_bits(d, 8);
    tick(8);
  endtask

  task automatic spi_read(input logic [6:0] a, input logic [7:0] e);
    send_bits({1'b0, a}, 8);
    tick(8);
    exp_rd_q.push_back(e);
    rd_active = 1'b1;
    send_bits(8'hFF, 8);
    tick(8);
  endtask

  task automatic check_loc(input string name, input logic [6:0] a, input logic [7:0] e);
    loc_addr = a;
    tick(2);
    check(name, {24'b0, loc_rdata}, {24'b0, e});
  endtask

  initial begin
    spi.sclk_i = 1'b1;
    spi.mosi_i = 1'b1;
    spi.cs_n_i = 1'b1;
    loc_addr   = '0;
`ifdef SPI_TARGET_ERR_CNT_EN
    err_clr    = 1'b0;
`endif
    tick(3);
    check("rst_miso", {31'b0, spi.miso_o}, 32'd1);
    check("rst_loc_rdata", {24'b0, loc_rdata}, 32'd0);
    check("rst_wr_strobe", {31'b0, wr_strobe}, 32'd0);
    check("rst_wr_addr", {25'b0, wr_addr}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
`ifdef SPI_TARGET_ERR_CNT_EN
    check("rst_err_cnt", {24'b0, err_cnt}, 32'd0);
`endif
    prst_n = 1'b1;
    tick(4);

    // single write 0x85 <- 0xA5
    frame_start();
    spi_write(7'h05, 8'hA5);
    frame_end();
    check("write_strobe_seen", exp_wr_q.size(), 32'd0);
    check_loc("loc_mem5", 7'h05, 8'hA5);

    // read back address 5
    frame_start();
    spi_read(7'h05, 8'hA5);
    frame_end();
    check("read_done", exp_rd_q.size(), 32'd0);
    check_loc("loc_mem5_after_read", 7'h05, 8'hA5);

    // three transactions in one frame
    frame_start();
    spi_write(7'h01, 8'h11);
    check("b2b_busy1", {31'b0, busy}, 32'd1);
    spi_write(7'h02, 8'h22);
    check("b2b_busy2", {31'b0, busy}, 32'd1);
    spi_read(7'h01, 8'h11);
    check("b2b_busy3", {31'b0, busy}, 32'd1);
    frame_end();
    check("b2b_idle_busy", {31'b0, busy}, 32'd0);
    check("b2b_strobes", exp_wr_q.size(), 32'd0);
    check("b2b_read_done", exp_rd_q.size(), 32'd0);
    check_loc("loc_mem2", 7'h02, 8'h22);

    // deselect after 4 data bits of write 0x90 <- 0xFF
    frame_start();
    send_bits(8'h90, 8);
    tick(8);
    send_bits(8'hFF, 4);
    frame_end();
    check("abort_busy", {31'b0, busy}, 32'd0);
    check_loc("abort_mem10", 7'h10, 8'h00);
`ifdef SPI_TARGET_ERR_CNT_EN
    check("abort_err_cnt", {24'b0, err_cnt}, 32'd1);
`endif

    // timeout after 3 address bits, then a complete write 0x83 <- 0x5A
    frame_start();
    send_bits(8'h84, 3);
    tick(IDLE_TIMEOUT + 16);
    spi_write(7'h03, 8'h5A);
    frame_end();
    check("tmo_strobes", exp_wr_q.size(), 32'd0);
    check_loc("tmo_mem3", 7'h03, 8'h5A);
    check_loc("tmo_mem4", 7'h04, 8'h00);
`ifdef SPI_TARGET_ERR_CNT_EN
    check("tmo_err_cnt", {24'b0, err_cnt}, 32'd2);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    tick(1);
    check("err_clr", {24'b0, err_cnt}, 32'd0);
`endif

    // reset asserted during bit 3 of a read of address 5 (0xA5)
    frame_start();
    send_bits(8'h05, 8);
    tick(8);
    send_bits(8'hFF, 3);
    tick(4);
    spi.sclk_i = 1'b0;
    tick(2);
    check("rd_bit3_before_rst", {31'b0, spi.miso_o}, 32'd0);
    prst_n = 1'b0;
    #1;
    check("rst_mid_miso", {31'b0, spi.miso_o}, 32'd1);
    check("rst_mid_busy", {31'b0, busy}, 32'd0);
    spi.sclk_i = 1'b1;
    spi.cs_n_i = 1'b1;
    spi.mosi_i = 1'b1;
    tick(3);
    prst_n = 1'b1;
    tick(4);
    check_loc("rst_mem5", 7'h05, 8'h00);
    check_loc("rst_mem1", 7'h01, 8'h00);
    check_loc("rst_mem2", 7'h02, 8'h00);
    check_loc("rst_mem3", 7'h03, 8'h00);

    tick(20);
    check("final_wr_queue", exp_wr_q.size(), 32'd0);
    check("final_rd_queue", exp_rd_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
